hs_txfis_framer: RTL and testbench

// - Builds SATA Data FISes from the DMA write-data stream and pushes them into the txll TX FIFO (txfifo_*).
// - Sits between the DMA engine's write-side buffer (upstream) and txll (downstream).
// - Prepends the Data FIS header dword, splits transfers into FISes of at most C_MAX_FIS_DW payload dwords, and marks sof/eof.
// - Holds off each new FIS until txll reports the previous one popped.

---
 rtl/hs_txfis_framer_pkg.sv | 21 ++
 rtl/hs_txfis_framer_if.sv | 49 ++++
 rtl/hs_txfis_framer_hdr.sv | 17 +
 rtl/hs_txfis_framer.sv | 208 ++++++++++++++++++++
 tb/tb_hs_txfis_framer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_txfis_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hs_pkg
// Brief    : Shared constants and state encoding for the TX Data FIS framer.
// Revision : 1.0 - initial release
// ============================================================================
package hs_pkg;

    localparam logic [7:0] FIS_DATA              = 8'h46;
    localparam int         C_MAX_FIS_DW_DEFAULT  = 2048;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_DATA      = 3'd2,
        ST_WAIT_POP  = 3'd3,
        ST_ABORT_EOF = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hs_txfis_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : hs_txfis_framer_if
// Brief    : Transfer control, source stream and txll TX FIFO signals.
// Revision : 1.0 - initial release
// ============================================================================
interface hs_txfis_framer_if;

    logic        xfer_start;
    logic [15:0] xfer_dwords;
    logic [3:0]  xfer_pm;
    logic        xfer_abort;
    logic        xfer_busy;
    logic        xfer_done;
    logic        xfer_err;

    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;

    logic [31:0] txfifo_data;
    logic        txfifo_sof;
    logic        txfifo_eof;
    logic        txfifo_wr_en;
    logic        txfifo_almost_full;
    logic        txfifo_eof_poped;

    // Environment side: DMA engine + txll
    modport master (
        output xfer_start, xfer_dwords, xfer_pm, xfer_abort,
        input  xfer_busy, xfer_done, xfer_err,
        output src_data, src_valid,
        input  src_ready,
        input  txfifo_data, txfifo_sof, txfifo_eof, txfifo_wr_en,
        output txfifo_almost_full, txfifo_eof_poped
    );

    // Framer side
    modport slave (
        input  xfer_start, xfer_dwords, xfer_pm, xfer_abort,
        output xfer_busy, xfer_done, xfer_err,
        input  src_data, src_valid,
        output src_ready,
        output txfifo_data, txfifo_sof, txfifo_eof, txfifo_wr_en,
        input  txfifo_almost_full, txfifo_eof_poped
    );

endinterface
`default_nettype wire

// File: rtl/hs_txfis_framer_hdr.sv
`default_nettype none
// ============================================================================
// Module   : hs_txfis_hdr
// Brief    : Combinational Data FIS header dword builder.
// Revision : 1.0 - initial release
// ============================================================================
module hs_txfis_hdr
    import hs_pkg::*;
(
    input  wire  [3:0]  i_pm,
    output logic [31:0] o_dword
);

    assign o_dword = {16'h0000, 4'h0, i_pm, FIS_DATA};

endmodule
`default_nettype wire

// File: rtl/hs_txfis_framer.sv
`default_nettype none
// ============================================================================
// Module   : hs_txfis_framer
// Brief    : Builds SATA Data FISes from the DMA write stream into the txll
//            TX FIFO. Optional statistics counters: HS_TXFIS_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hs_txfis_framer
    import hs_pkg::*;
#(
    parameter int C_MAX_FIS_DW = C_MAX_FIS_DW_DEFAULT
)
(
    input  wire          sys_clk,
    input  wire          sys_rst,
    hs_txfis_framer_if.slave bus,
    output logic         txfifo_clk,
    output logic [15:0]  stat_fis_cnt,
    output logic [15:0]  stat_stall_cnt
);

    localparam logic [11:0] c_MAX_FCNT = 12'(C_MAX_FIS_DW);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_rem;
    logic [15:0] w_rem_nxt;
    logic [11:0] r_fcnt;
    logic [11:0] w_fcnt_nxt;
    logic [3:0]  r_pm;
    logic [3:0]  w_pm_nxt;

    logic        w_wr;
    logic        w_sof;
    logic        w_eof;
    logic [31:0] w_data;
    logic        w_done;
    logic        w_err;
    logic        w_src_ready;
    logic [31:0] w_hdr;
    logic [11:0] w_fis_len;

    logic [31:0] r_data;
    logic        r_sof;
    logic        r_eof;
    logic        r_wr_en;
    logic        r_done;
    logic        r_err;

    hs_txfis_hdr u_hdr (
        .i_pm    (r_pm),
        .o_dword (w_hdr)
    );

    assign w_fis_len = (r_rem > 16'(C_MAX_FIS_DW)) ? c_MAX_FCNT : r_rem[11:0];

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_fcnt_nxt  = r_fcnt;
        w_pm_nxt    = r_pm;
        w_wr        = 1'b0;
        w_sof       = 1'b0;
        w_eof       = 1'b0;
        w_data      = 32'h0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_src_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Abort wins over a coincident start: neither takes effect.
                if (bus.xfer_start && !bus.xfer_abort) begin
                    w_rem_nxt = bus.xfer_dwords;
                    w_pm_nxt  = bus.xfer_pm;
                    if (bus.xfer_dwords == 16'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (bus.xfer_abort) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!bus.txfifo_almost_full) begin
                    w_wr        = 1'b1;
                    w_sof       = 1'b1;
                    w_data      = w_hdr;
                    w_fcnt_nxt  = w_fis_len;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_src_ready = !bus.txfifo_almost_full;
                // A word accepted alongside an abort is dropped; the frame is
                // closed by a dummy eof dword instead.
                if (bus.xfer_abort) begin
                    w_state_nxt = ST_ABORT_EOF;
                end else if (bus.src_valid && w_src_ready) begin
                    w_wr   = 1'b1;
                    w_data = bus.src_data;
                    if (r_fcnt != 12'd0) w_fcnt_nxt = r_fcnt - 12'd1;
                    if (r_rem  != 16'd0) w_rem_nxt  = r_rem  - 16'd1;
                    if (r_fcnt == 12'd1) begin
                        w_eof       = 1'b1;
                        w_state_nxt = ST_WAIT_POP;
                    end
                end
            end
            ST_WAIT_POP: begin
                if (bus.xfer_abort) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.txfifo_eof_poped) begin
                    if (r_rem == 16'd0) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_ABORT_EOF: begin
                if (!bus.txfifo_almost_full) begin
                    w_wr        = 1'b1;
                    w_eof       = 1'b1;
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_rem   <= 16'd0;
            r_fcnt  <= 12'd0;
            r_pm    <= 4'd0;
            r_data  <= 32'h0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_pm    <= w_pm_nxt;
            r_data  <= w_data;
            r_sof   <= w_sof;
            r_eof   <= w_eof;
            r_wr_en <= w_wr;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign bus.xfer_busy    = (r_state != ST_IDLE);
    assign bus.xfer_done    = r_done;
    assign bus.xfer_err     = r_err;
    assign bus.src_ready    = w_src_ready;
    assign bus.txfifo_data  = r_data;
    assign bus.txfifo_sof   = r_sof;
    assign bus.txfifo_eof   = r_eof;
    assign bus.txfifo_wr_en = r_wr_en;
    assign txfifo_clk       = sys_clk;

`ifdef HS_TXFIS_STATS_EN
    logic [15:0] r_fis_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = bus.txfifo_almost_full &&
                     ((r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_ABORT_EOF));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fis_cnt   <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_wr && w_sof && (r_fis_cnt != 16'hFFFF)) begin
                r_fis_cnt <= r_fis_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stat_fis_cnt   = r_fis_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`else
    assign stat_fis_cnt   = 16'd0;
    assign stat_stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_txfis_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_txfis_framer
// Brief    : Scoreboard bench for hs_txfis_framer (C_MAX_FIS_DW = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_txfis_framer;

    localparam int MAX_DW = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        txfifo_clk;
    logic [15:0] stat_fis_cnt;
    logic [15:0] stat_stall_cnt;

    hs_txfis_framer_if bus ();

    hs_txfis_framer #(.C_MAX_FIS_DW(MAX_DW)) u_dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .bus            (bus),
        .txfifo_clk     (txfifo_clk),
        .stat_fis_cnt   (stat_fis_cnt),
        .stat_stall_cnt (stat_stall_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_vec     = 0;
    int          n_err     = 0;
    logic [33:0] exp_wr[$];     // {sof, eof, data}
    logic        exp_done[$];   // expected err with each done
    logic [31:0] src_q[$];
    int          wr_total  = 0;
    int          eof_seen  = 0;
    int          done_cnt  = 0;
    int          hs_cnt    = 0;
    int          popped    = 0;
    int          exp_fis   = 0;
    logic        hs_pending = 1'b0;
    logic        af_prev    = 1'b0;
    logic        sb_off     = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (!sb_off) begin
            if (af_prev) check("no_wr_on_af", 64'(bus.txfifo_wr_en), 64'(0));
            if (bus.txfifo_almost_full) check("rdy_on_af", 64'(bus.src_ready), 64'(0));
            if (bus.txfifo_wr_en) begin
                if (exp_wr.size() == 0)
                    check("wr_unexpected", 64'(bus.txfifo_wr_en), 64'(0));
                else
                    check("wr_word", 64'({bus.txfifo_sof, bus.txfifo_eof, bus.txfifo_data}),
                          64'(exp_wr.pop_front()));
            end
            if (bus.xfer_done) begin
                if (exp_done.size() == 0)
                    check("done_unexpected", 64'(bus.xfer_done), 64'(0));
                else
                    check("done_err", 64'(bus.xfer_err), 64'(exp_done.pop_front()));
            end
        end
        if (bus.txfifo_wr_en) begin
            wr_total++;
            if (bus.txfifo_eof) eof_seen++;
        end
        if (bus.xfer_done) done_cnt++;
        hs_pending = bus.src_valid && bus.src_ready;
        af_prev    = bus.txfifo_almost_full;
    end

    // Source: presents the head of src_q, advances after each handshake
    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = 32'h0;
        forever begin
            @(posedge sys_clk);
            #2;
            if (hs_pending && (src_q.size() > 0)) begin
                void'(src_q.pop_front());
                hs_cnt++;
            end
            if (src_q.size() > 0) begin
                bus.src_valid = 1'b1;
                bus.src_data  = src_q[0];
            end else begin
                bus.src_valid = 1'b0;
                bus.src_data  = 32'h0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic logic [33:0] hdr_word(input logic [3:0] pm);
        return {1'b1, 1'b0, 16'h0000, 4'h0, pm, 8'h46};
    endfunction

    // Reference framing: split into FISes of at most MAX_DW payload dwords
    task automatic load(input int dw, input logic [3:0] pm);
        int          rem;
        int          f;
        logic [31:0] w;
        rem = dw;
        while (rem > 0) begin
            f = (rem > MAX_DW) ? MAX_DW : rem;
            exp_wr.push_back(hdr_word(pm));
            exp_fis++;
            for (int j = 0; j < f; j++) begin
                w = $urandom();
                src_q.push_back(w);
                exp_wr.push_back({1'b0, (j == f - 1), w});
            end
            rem -= f;
        end
        exp_done.push_back(1'b0);
    endtask

    task automatic pulse_start(input int dw, input logic [3:0] pm);
        bus.xfer_dwords = 16'(dw);
        bus.xfer_pm     = pm;
        bus.xfer_start  = 1'b1;
        cyc();
        bus.xfer_start  = 1'b0;
    endtask

    // txll model: acknowledge each eof after a hold-off window
    task automatic service(input int nfis);
        int k;
        int t;
        for (int i = 0; i < nfis; i++) begin
            t = 0;
            while ((eof_seen <= popped) && (t < 200)) begin
                cyc();
                t++;
            end
            check("eof_arrived", 64'(eof_seen > popped), 64'(1));
            k = wr_total;
            cyc(4);
            check("hold_off", 64'(wr_total), 64'(k));
            bus.txfifo_eof_poped = 1'b1;
            cyc();
            bus.txfifo_eof_poped = 1'b0;
            popped++;
        end
    endtask

    task automatic wait_done(input int base);
        int t;
        t = 0;
        while ((done_cnt == base) && (t < 100)) begin
            cyc();
            t++;
        end
        cyc(3);
        check("one_done", 64'(done_cnt), 64'(base + 1));
        check("busy_after_done", 64'(bus.xfer_busy), 64'(0));
    endtask

    task automatic xfer(input int dw, input logic [3:0] pm, input int nfis);
        int base;
        base = done_cnt;
        load(dw, pm);
        pulse_start(dw, pm);
        check("busy_after_start", 64'(bus.xfer_busy), 64'(1));
        service(nfis);
        wait_done(base);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wr"},    64'(bus.txfifo_wr_en), 64'(0));
        check({tag, "_sof"},   64'(bus.txfifo_sof),   64'(0));
        check({tag, "_eof"},   64'(bus.txfifo_eof),   64'(0));
        check({tag, "_data"},  64'(bus.txfifo_data),  64'(0));
        check({tag, "_done"},  64'(bus.xfer_done),    64'(0));
        check({tag, "_err"},   64'(bus.xfer_err),     64'(0));
        check({tag, "_busy"},  64'(bus.xfer_busy),    64'(0));
        check({tag, "_rdy"},   64'(bus.src_ready),    64'(0));
        check({tag, "_sfis"},  64'(stat_fis_cnt),     64'(0));
        check({tag, "_sstl"},  64'(stat_stall_cnt),   64'(0));
    endtask

    initial begin
        int base;
        int hsb;
        int k;
        int t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;

        bus.xfer_start         = 1'b0;
        bus.xfer_dwords        = 16'd0;
        bus.xfer_pm            = 4'd0;
        bus.xfer_abort         = 1'b0;
        bus.txfifo_almost_full = 1'b0;
        bus.txfifo_eof_poped   = 1'b0;

        cyc(3);
        check_quiet("reset");
        check("txfifo_clk", 64'(txfifo_clk), 64'(1));
        sys_rst = 1'b0;
        cyc(2);

        // Single FIS, pm=3
        xfer(4, 4'h3, 1);

        // Multi-FIS split 4/4/2
        xfer(10, 4'h5, 3);

        // Zero-length transfer
        k = wr_total;
        base = done_cnt;
        exp_done.push_back(1'b0);
        pulse_start(0, 4'h7);
        check("zero_done", 64'(bus.xfer_done), 64'(1));
        check("zero_busy", 64'(bus.xfer_busy), 64'(0));
        cyc();
        check("zero_done_pulse", 64'(bus.xfer_done), 64'(0));
        check("zero_busy2", 64'(bus.xfer_busy), 64'(0));
        cyc(2);
        check("zero_no_wr", 64'(wr_total), 64'(k));
        check("zero_done_cnt", 64'(done_cnt), 64'(base + 1));

        // Back-pressure: almost_full held for 20 cycles inside a FIS
        base = done_cnt;
        hsb  = hs_cnt;
        load(8, 4'h2);
        pulse_start(8, 4'h2);
        t = 0;
        while ((hs_cnt < hsb + 2) && (t < 50)) begin
            cyc();
            t++;
        end
        bus.txfifo_almost_full = 1'b1;
        cyc(2);
        k = wr_total;
        cyc(18);
        check("stall_no_wr", 64'(wr_total), 64'(k));
        bus.txfifo_almost_full = 1'b0;
        service(2);
        wait_done(base);

        // Abort after two data words; third word dropped with the abort
        base = done_cnt;
        hsb  = hs_cnt;
        w0 = $urandom();
        w1 = $urandom();
        w2 = $urandom();
        src_q.push_back(w0);
        src_q.push_back(w1);
        exp_wr.push_back(hdr_word(4'h6));
        exp_fis++;
        exp_wr.push_back({1'b0, 1'b0, w0});
        exp_wr.push_back({1'b0, 1'b0, w1});
        exp_wr.push_back({1'b0, 1'b1, 32'h0});
        exp_done.push_back(1'b1);
        pulse_start(8, 4'h6);
        t = 0;
        while ((hs_cnt < hsb + 2) && (t < 50)) begin
            cyc();
            t++;
        end
        src_q.push_back(w2);
        bus.xfer_abort = 1'b1;
        cyc();
        bus.xfer_abort = 1'b0;
        wait_done(base);

        // eof_poped while idle is ignored
        popped = eof_seen;
        base = done_cnt;
        bus.txfifo_eof_poped = 1'b1;
        cyc();
        bus.txfifo_eof_poped = 1'b0;
        cyc(2);
        check("poped_idle_busy", 64'(bus.xfer_busy), 64'(0));
        check("poped_idle_done", 64'(done_cnt), 64'(base));

        // Start and abort together in IDLE: nothing happens
        k = wr_total;
        base = done_cnt;
        bus.xfer_dwords = 16'd3;
        bus.xfer_pm     = 4'h1;
        bus.xfer_start  = 1'b1;
        bus.xfer_abort  = 1'b1;
        cyc();
        bus.xfer_start  = 1'b0;
        bus.xfer_abort  = 1'b0;
        check("sa_busy", 64'(bus.xfer_busy), 64'(0));
        cyc(3);
        check("sa_no_wr", 64'(wr_total), 64'(k));
        check("sa_no_done", 64'(done_cnt), 64'(base));

`ifdef HS_TXFIS_STATS_EN
        check("stat_fis", 64'(stat_fis_cnt), 64'(exp_fis));
        check("stat_stall", 64'(stat_stall_cnt), 64'(20));
`else
        check("stat_fis_off", 64'(stat_fis_cnt), 64'(0));
        check("stat_stall_off", 64'(stat_stall_cnt), 64'(0));
`endif

        // Reset in the middle of a frame
        sb_off = 1'b1;
        hsb = hs_cnt;
        for (int i = 0; i < 8; i++) src_q.push_back($urandom());
        pulse_start(8, 4'h1);
        t = 0;
        while ((hs_cnt < hsb + 1) && (t < 50)) begin
            cyc();
            t++;
        end
        check("rst_in_data", 64'(bus.xfer_busy), 64'(1));
        sys_rst = 1'b1;
        cyc();
        check_quiet("midrst");
        sys_rst = 1'b0;
        src_q.delete();
        cyc(2);
        popped = eof_seen;
        sb_off = 1'b0;

        // Normal operation after reset
        xfer(3, 4'h9, 1);

        check("sb_wr_empty", 64'(exp_wr.size()), 64'(0));
        check("sb_done_empty", 64'(exp_done.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
